alu_seq_arbiter: RTL

Shares one WIDTH-bit ALU between two requesters using round-robin arbitration and valid/ready handshakes. Sequences each accepted operation through a registered execute phase. Single-cycle ops (AND/OR/XOR/ADD/SUB) and a multi-cycle shift-add multiply (MUL) run on the ALU's add path. Each result and its N/Z/C/V flags are held in a response buffer until the consumer accepts it. Sits between the lab's register/control front-end and the ALU datapath.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_seq_arbiter_alu_core.sv | 26 ++
 rtl/alu_seq_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag bit positions shared by the sequenced ALU arbiter
package alu_seq_pkg;
  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_MUL = 4'd8
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  function automatic logic op_legal(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL};
  endfunction
endpackage

// File: rtl/alu_seq_arbiter_alu_core.sv
// alu_core: combinational WIDTH-bit ALU returning result and {N,Z,C,V}; unknown opcodes yield 0
module alu_core import alu_seq_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);
  logic [WIDTH:0] sum, dif;
  logic sub, arith;
  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  assign sub   = op == OP_SUB;
  assign arith = op == OP_ADD || sub;
  assign res = op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_XOR ? a ^ b :
               op == OP_ADD ? sum[WIDTH-1:0] :
               sub          ? dif[WIDTH-1:0] : '0;
  assign flags[FLAG_N] = res[WIDTH-1];
  assign flags[FLAG_Z] = res == '0;
  assign flags[FLAG_C] = arith & (sub ? dif[WIDTH] : sum[WIDTH]);
  assign flags[FLAG_V] = arith & (a[WIDTH-1] == (b[WIDTH-1] ^ sub)) & (res[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_seq_arbiter.sv
// alu_seq_arbiter: round-robin shared ALU with registered execute and response buffer; ALU_SEQ_ERR_EN adds resp_err
module alu_seq_arbiter import alu_seq_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags
`ifdef ALU_SEQ_ERR_EN
  ,
  output logic             resp_err
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_e state, state_nx;
  logic ptr, gnt, accept, id_q, is_mul, done;
  logic [3:0] op_q, alu_op, alu_flags, mul_flags;
  logic [WIDTH-1:0] a_q, b_q, acc, alu_a, alu_b, alu_res;
  logic [CW-1:0] cnt;
  assign gnt    = req_valid[ptr] ? ptr : ~ptr;
  assign is_mul = op_q == OP_MUL;
  assign done   = !is_mul || cnt == CW'(WIDTH - 1);
  // MUL reuses the adder: acc += multiplicand shifted k places when multiplier bit k is set
  assign alu_op = is_mul ? OP_ADD : op_q;
  assign alu_a  = is_mul ? acc : a_q;
  assign alu_b  = is_mul ? (b_q[0] ? a_q : '0) : b_q;
  assign mul_flags = alu_flags & ~((4'b1 << FLAG_C) | (4'b1 << FLAG_V));
  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op    (alu_op),
    .a     (alu_a),
    .b     (alu_b),
    .res   (alu_res),
    .flags (alu_flags)
  );
  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        accept    = |req_valid;
        req_ready = accept ? 2'b01 << gnt : 2'b00;
        state_nx  = accept ? S_EXEC : S_IDLE;
      end
      S_EXEC:  state_nx = done ? S_RESP : S_EXEC;
      S_RESP:  state_nx = (resp_valid && resp_ready) ? S_IDLE : S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 1'b0;
      id_q        <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      cnt         <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_flags  <= '0;
    end else begin
      if (accept) begin
        ptr  <= ~gnt;
        id_q <= gnt;
        op_q <= gnt ? req_op1 : req_op0;
        a_q  <= gnt ? req_a1 : req_a0;
        b_q  <= gnt ? req_b1 : req_b0;
        acc  <= '0;
        cnt  <= '0;
      end
      if (state == S_EXEC) begin
        if (is_mul) begin
          acc <= alu_res;
          a_q <= a_q << 1;
          b_q <= b_q >> 1;
          cnt <= cnt + 1'b1;
        end
        if (done) begin
          resp_id     <= id_q;
          resp_result <= alu_res;
          resp_flags  <= is_mul ? mul_flags : alu_flags;
        end
      end
      // buffer is filled on the last EXEC edge and published one edge later
      resp_valid <= state == S_RESP && !(resp_valid && resp_ready);
    end
  end
`ifdef ALU_SEQ_ERR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) resp_err <= 1'b0;
    else if (state == S_EXEC && done) resp_err <= !op_legal(op_q);
    else if (resp_valid && resp_ready) resp_err <= 1'b0;
`endif
endmodule
